vec_issue_ctrl: RTL and testbench
=================================

Name: vec_issue_ctrl

Overview:
Initiator-side controller that drives the start/op command interface of a bank of vector lanes.
- Accepts one vector instruction at a time on a valid/ready input.
- Broadcasts op, operand addresses and scalar to all lanes_p lanes and pulses a one-cycle start.
- Collects each lane's one-cycle completion pulse and returns a single completion response upstream.
- Sits between the vector instruction front-end and the lane array.

Parameters:
lanes_p, 4, number of lanes driven; width of the done vector
els_p, 32, vectors in the register file; vector address width = clog2(els_p)
vdw_p, 32, scalar/element width in bits
op_width_p, 3, ALU opcode width
timeout_p, 64, watchdog limit in cycles (used only with VEC_ISSUE_TIMEOUT_EN)

Ports:
clk_i  in  1  single clock, rising edge
reset_n_i  in  1  asynchronous, active-low reset
v_i  in  1  instruction valid
ready_o  out  1  controller can accept an instruction
op_i  in  op_width_p  instruction opcode
vd_i / vs1_i / vs2_i  in  clog2(els_p) each  destination and source vector addresses
scalar_i  in  vdw_p  scalar operand
lane_op_o  out  op_width_p  broadcast opcode
lane_vd_o / lane_vs1_o / lane_vs2_o  out  clog2(els_p)  broadcast addresses
lane_scalar_o  out  vdw_p  broadcast scalar
lane_start_o  out  1  one-cycle start pulse to all lanes
lane_done_i  in  lanes_p  per-lane one-cycle completion pulse
done_v_o  out  1  completion response valid
done_ready_i  in  1  upstream accepts the response
done_vd_o  out  clog2(els_p)  vd of the completed instruction
done_err_o  out  1  completion was forced by the watchdog
busy_o  out  1  controller is not in IDLE

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; all instruction registers and the done mask cleared.
  - ready_o=1, lane_start_o=0, done_v_o=0, done_err_o=0, busy_o=0.
  - All lane_* buses are 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - ready_o=1.
  - On v_i&ready_o, capture op/vd/vs1/vs2/scalar into registers and go to ISSUE.
- ISSUE:
  - Lasts exactly one cycle; lane_start_o=1; done mask cleared; go to WAIT.
  - Latency is fixed: accept at edge N, lane_start_o high during cycle N+1.
- WAIT:
  - Sticky mask: mask <= mask | lane_done_i.
  - Leave when (mask | lane_done_i) is all ones, including the case where the final bits arrive in the same cycle. Go to RESP.
  - Lanes may finish in any order and any cycle.
  - A repeated pulse from an already-set lane has no effect.
- RESP:
  - done_v_o=1 and done_vd_o is stable until done_v_o&done_ready_i, then go to IDLE.
  - done_ready_i held high allows back-to-back instructions: one instruction every 4 cycles minimum, plus lane latency.
- lane_* buses hold the captured instruction from ISSUE through RESP, and in IDLE until the next capture. They change only on capture.
- ready_o=0 in ISSUE, WAIT and RESP, so at most one instruction is in flight.
- lane_done_i is ignored in IDLE, ISSUE and RESP.
- Reset asserted mid-operation returns to IDLE immediately and drops any in-flight response.

Optional Feature:
VEC_ISSUE_TIMEOUT_EN
- Defined:
  - Counter of width clog2(timeout_p+1) clears on entry to WAIT and increments each WAIT cycle.
  - If the count reaches timeout_p before all done bits are set, go to RESP with done_err_o=1.
  - done_err_o clears when the response is accepted.
  - A normal completion that occurs in the same cycle as the timeout wins, so done_err_o=0.
- Undefined: no counter; done_err_o tied 0; WAIT lasts until all lanes report.

Test Plan:
- Reset then v_i=1, op=3'd2, vd=5, vs1=1, vs2=2, scalar=32'hA5 at edge 0 -> lane_start_o=1 only in cycle 1, lane_vd_o=5, lane_scalar_o=32'hA5, ready_o=0 until response accepted.
- lane_done_i pulses 4'b0001, 4'b0100, 4'b1010 on separate cycles -> done_v_o rises the cycle after the 4'b1010 pulse, done_vd_o=5, done_err_o=0.
- All lanes pulse 4'b1111 in one cycle with done_ready_i=0 for 3 cycles -> done_v_o held 3+ cycles, done_vd_o stable, returns to IDLE the cycle after done_ready_i=1.
- Lane 2 pulses twice and lane 0 pulses while in IDLE -> no early completion; response only after lanes 0, 1 and 3 pulse in WAIT.
- Deassert reset_n_i asynchronously during WAIT -> outputs return to reset values immediately; the next instruction issues normally.
- With VEC_ISSUE_TIMEOUT_EN, timeout_p=64, only lanes 0-2 respond -> done_v_o=1 with done_err_o=1 after 64 WAIT cycles. Without the macro -> done_v_o stays 0.

Source files
------------

// File: rtl/vec_issue_ctrl_if.sv
// Instruction, lane-broadcast and completion signals of vec_issue_ctrl.
// slave  : the controller's view
// master : the environment's view (front-end plus lane array)
interface vec_issue_ctrl_if #(
  parameter int unsigned lanes_p    = 4,
  parameter int unsigned els_p      = 32,
  parameter int unsigned vdw_p      = 32,
  parameter int unsigned op_width_p = 3
);
  localparam int unsigned AddrW = $clog2(els_p);

  // upstream instruction handshake
  logic                  v_i;
  logic                  ready_o;
  logic [op_width_p-1:0] op_i;
  logic [AddrW-1:0]      vd_i;
  logic [AddrW-1:0]      vs1_i;
  logic [AddrW-1:0]      vs2_i;
  logic [vdw_p-1:0]      scalar_i;

  // lane broadcast
  logic [op_width_p-1:0] lane_op_o;
  logic [AddrW-1:0]      lane_vd_o;
  logic [AddrW-1:0]      lane_vs1_o;
  logic [AddrW-1:0]      lane_vs2_o;
  logic [vdw_p-1:0]      lane_scalar_o;
  logic                  lane_start_o;
  logic [lanes_p-1:0]    lane_done_i;

  // completion response and status
  logic                  done_v_o;
  logic                  done_ready_i;
  logic [AddrW-1:0]      done_vd_o;
  logic                  done_err_o;
  logic                  busy_o;

  modport slave (
    input  v_i, op_i, vd_i, vs1_i, vs2_i, scalar_i, lane_done_i, done_ready_i,
    output ready_o, lane_op_o, lane_vd_o, lane_vs1_o, lane_vs2_o, lane_scalar_o,
           lane_start_o, done_v_o, done_vd_o, done_err_o, busy_o
  );

  modport master (
    output v_i, op_i, vd_i, vs1_i, vs2_i, scalar_i, lane_done_i, done_ready_i,
    input  ready_o, lane_op_o, lane_vd_o, lane_vs1_o, lane_vs2_o, lane_scalar_o,
           lane_start_o, done_v_o, done_vd_o, done_err_o, busy_o
  );
endinterface

// File: rtl/vec_issue_ctrl.sv
// vec_issue_ctrl: issues one vector instruction at a time to a bank of lanes,
// collects per-lane completion pulses and returns one response upstream.
// Optional watchdog: define VEC_ISSUE_TIMEOUT_EN to force a response with
// done_err_o=1 after timeout_p WAIT cycles without full completion.
module vec_issue_ctrl #(
  parameter int unsigned lanes_p    = 4,
  parameter int unsigned els_p      = 32,
  parameter int unsigned vdw_p      = 32,
  parameter int unsigned op_width_p = 3,
  parameter int unsigned timeout_p  = 64
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  vec_issue_ctrl_if.slave  bus
);

  localparam int unsigned AddrW = $clog2(els_p);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [op_width_p-1:0] op_q, op_d;
  logic [AddrW-1:0]      vd_q, vd_d;
  logic [AddrW-1:0]      vs1_q, vs1_d;
  logic [AddrW-1:0]      vs2_q, vs2_d;
  logic [vdw_p-1:0]      scalar_q, scalar_d;
  logic [lanes_p-1:0]    mask_q, mask_d;
  logic                  ready_q, ready_d;
  logic                  start_q, start_d;
  logic                  done_v_q, done_v_d;
  logic                  busy_q, busy_d;
  logic                  all_done_c;

`ifdef VEC_ISSUE_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(timeout_p + 1);
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic                  err_q, err_d;
`endif

  // Next-state, capture, completion mask and registered-output decode
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    vd_d       = vd_q;
    vs1_d      = vs1_q;
    vs2_d      = vs2_q;
    scalar_d   = scalar_q;
    mask_d     = mask_q;
    all_done_c = &(mask_q | bus.lane_done_i);
`ifdef VEC_ISSUE_TIMEOUT_EN
    cnt_d      = cnt_q;
    err_d      = err_q;
`endif

    case (state_q)
      IDLE: begin
        if (bus.v_i && ready_q) begin
          op_d     = bus.op_i;
          vd_d     = bus.vd_i;
          vs1_d    = bus.vs1_i;
          vs2_d    = bus.vs2_i;
          scalar_d = bus.scalar_i;
          state_d  = ISSUE;
        end
      end
      ISSUE: begin
        mask_d  = '0;
`ifdef VEC_ISSUE_TIMEOUT_EN
        cnt_d   = '0;
`endif
        state_d = WAIT;
      end
      WAIT: begin
        mask_d = mask_q | bus.lane_done_i;
        // normal completion takes priority over a coincident timeout
        if (all_done_c) begin
          state_d = RESP;
        end
`ifdef VEC_ISSUE_TIMEOUT_EN
        else if (cnt_q == CntW'(timeout_p - 1)) begin
          state_d = RESP;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
`endif
      end
      RESP: begin
        if (bus.done_ready_i) begin
          state_d = IDLE;
`ifdef VEC_ISSUE_TIMEOUT_EN
          err_d   = 1'b0;
`endif
        end
      end
      default: state_d = IDLE;
    endcase

    ready_d  = (state_d == IDLE);
    start_d  = (state_d == ISSUE);
    done_v_d = (state_d == RESP);
    busy_d   = (state_d != IDLE);
  end

  // State, instruction and output registers
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= IDLE;
      op_q     <= '0;
      vd_q     <= '0;
      vs1_q    <= '0;
      vs2_q    <= '0;
      scalar_q <= '0;
      mask_q   <= '0;
      ready_q  <= 1'b1;
      start_q  <= 1'b0;
      done_v_q <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      vd_q     <= vd_d;
      vs1_q    <= vs1_d;
      vs2_q    <= vs2_d;
      scalar_q <= scalar_d;
      mask_q   <= mask_d;
      ready_q  <= ready_d;
      start_q  <= start_d;
      done_v_q <= done_v_d;
      busy_q   <= busy_d;
    end
  end

`ifdef VEC_ISSUE_TIMEOUT_EN
  // Watchdog counter and error flag
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign bus.done_err_o = err_q;
`else
  assign bus.done_err_o = 1'b0;
`endif

  assign bus.ready_o       = ready_q;
  assign bus.busy_o        = busy_q;
  assign bus.lane_start_o  = start_q;
  assign bus.lane_op_o     = op_q;
  assign bus.lane_vd_o     = vd_q;
  assign bus.lane_vs1_o    = vs1_q;
  assign bus.lane_vs2_o    = vs2_q;
  assign bus.lane_scalar_o = scalar_q;
  assign bus.done_v_o      = done_v_q;
  assign bus.done_vd_o     = vd_q;

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// Scoreboard bench for vec_issue_ctrl: stimulus pushes expected lane
// broadcasts and responses; monitors pop and compare on start and accept.
module tb_vec_issue_ctrl;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  vd;
    logic [4:0]  vs1;
    logic [4:0]  vs2;
    logic [31:0] scalar;
  } issue_t;

  typedef struct {
    logic [4:0] vd;
    logic       err;
  } resp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  issue_t issue_q[$];
  resp_t  resp_q[$];

  vec_issue_ctrl_if #(.lanes_p(4), .els_p(32), .vdw_p(32), .op_width_p(3)) bus ();

  vec_issue_ctrl #(
    .lanes_p(4), .els_p(32), .vdw_p(32), .op_width_p(3), .timeout_p(64)
  ) dut (
    .clk_i     (clk),
    .reset_n_i (rst_n),
    .bus       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // Lane-broadcast monitor: every start pulse must carry the next issued instruction
  always @(negedge clk) begin
    if (rst_n && bus.lane_start_o) begin
      if (issue_q.size() == 0) begin
        check("unexpected_start", 64'd1, 64'd0);
      end else begin
        issue_t e;
        e = issue_q.pop_front();
        check("lane_op",     64'(bus.lane_op_o),     64'(e.op));
        check("lane_vd",     64'(bus.lane_vd_o),     64'(e.vd));
        check("lane_vs1",    64'(bus.lane_vs1_o),    64'(e.vs1));
        check("lane_vs2",    64'(bus.lane_vs2_o),    64'(e.vs2));
        check("lane_scalar", 64'(bus.lane_scalar_o), 64'(e.scalar));
      end
    end
  end

  // Response monitor: compare at the accepting cycle
  always @(negedge clk) begin
    if (rst_n && bus.done_v_o && bus.done_ready_i) begin
      if (resp_q.size() == 0) begin
        check("unexpected_resp", 64'd1, 64'd0);
      end else begin
        resp_t r;
        r = resp_q.pop_front();
        check("done_vd",  64'(bus.done_vd_o),  64'(r.vd));
        check("done_err", 64'(bus.done_err_o), 64'(r.err));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one instruction; returns #1 into the ISSUE cycle
  task automatic send(input logic [2:0] op, input logic [4:0] vd, input logic [4:0] vs1,
                      input logic [4:0] vs2, input logic [31:0] sc, input logic err);
    issue_t e;
    resp_t  r;
    e.op = op; e.vd = vd; e.vs1 = vs1; e.vs2 = vs2; e.scalar = sc;
    r.vd = vd; r.err = err;
    issue_q.push_back(e);
    resp_q.push_back(r);
    bus.v_i      = 1'b1;
    bus.op_i     = op;
    bus.vd_i     = vd;
    bus.vs1_i    = vs1;
    bus.vs2_i    = vs2;
    bus.scalar_i = sc;
    tick();
    bus.v_i = 1'b0;
  endtask

  // One-cycle lane completion pulse, sampled at the next edge
  task automatic pulse(input logic [3:0] m);
    bus.lane_done_i = m;
    tick();
    bus.lane_done_i = 4'b0000;
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_ready"},  64'(bus.ready_o),       64'd1);
    check({tag, "_start"},  64'(bus.lane_start_o),  64'd0);
    check({tag, "_done_v"}, 64'(bus.done_v_o),      64'd0);
    check({tag, "_err"},    64'(bus.done_err_o),    64'd0);
    check({tag, "_busy"},   64'(bus.busy_o),        64'd0);
    check({tag, "_lvd"},    64'(bus.lane_vd_o),     64'd0);
    check({tag, "_lsc"},    64'(bus.lane_scalar_o), 64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "bench timeout");
  end

  initial begin
    bit early;
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    bus.v_i = 1'b0; bus.op_i = '0; bus.vd_i = '0; bus.vs1_i = '0; bus.vs2_i = '0;
    bus.scalar_i = '0; bus.lane_done_i = '0; bus.done_ready_i = 1'b1;

    // reset values
    repeat (2) @(negedge clk);
    check_reset_vals("rst");
    tick();
    rst_n = 1'b1;
    tick();

    // basic issue, out-of-order lane completions
    send(3'd2, 5'd5, 5'd1, 5'd2, 32'hA5, 1'b0);
    @(negedge clk);
    check("t1_start_issue", 64'(bus.lane_start_o), 64'd1);
    check("t1_ready_issue", 64'(bus.ready_o), 64'd0);
    check("t1_busy_issue",  64'(bus.busy_o), 64'd1);
    tick();
    @(negedge clk);
    check("t1_start_wait", 64'(bus.lane_start_o), 64'd0);
    check("t1_ready_wait", 64'(bus.ready_o), 64'd0);
    pulse(4'b0001);
    @(negedge clk);
    check("t1_dv_after_0001", 64'(bus.done_v_o), 64'd0);
    pulse(4'b0100);
    @(negedge clk);
    check("t1_dv_after_0100", 64'(bus.done_v_o), 64'd0);
    pulse(4'b1010);
    @(negedge clk);
    check("t1_dv_after_1010", 64'(bus.done_v_o), 64'd1);
    check("t1_ready_resp", 64'(bus.ready_o), 64'd0);
    tick();
    @(negedge clk);
    check("t1_ready_idle", 64'(bus.ready_o), 64'd1);
    check("t1_dv_idle",    64'(bus.done_v_o), 64'd0);
    check("t1_lvd_hold",   64'(bus.lane_vd_o), 64'd5);

    // all lanes at once, response back-pressured for 3 cycles
    bus.done_ready_i = 1'b0;
    tick();
    send(3'd1, 5'd7, 5'd3, 5'd4, 32'hDEAD_BEEF, 1'b0);
    tick();
    pulse(4'b1111);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_dv_held",  64'(bus.done_v_o), 64'd1);
      check("t2_vd_held",  64'(bus.done_vd_o), 64'd7);
      check("t2_ready_lo", 64'(bus.ready_o), 64'd0);
      tick();
    end
    bus.done_ready_i = 1'b1;
    tick();
    @(negedge clk);
    check("t2_idle_ready", 64'(bus.ready_o), 64'd1);
    check("t2_idle_busy",  64'(bus.busy_o), 64'd0);

    // lane pulses in IDLE/ISSUE ignored, repeated lane 2 pulse ignored
    pulse(4'b0001);
    send(3'd4, 5'd9, 5'd10, 5'd11, 32'h1234_5678, 1'b0);
    pulse(4'b1011);
    pulse(4'b0100);
    @(negedge clk);
    check("t3_dv_l2", 64'(bus.done_v_o), 64'd0);
    pulse(4'b0100);
    @(negedge clk);
    check("t3_dv_l2_rep", 64'(bus.done_v_o), 64'd0);
    pulse(4'b0001);
    @(negedge clk);
    check("t3_dv_l0", 64'(bus.done_v_o), 64'd0);
    pulse(4'b0010);
    @(negedge clk);
    check("t3_dv_l1", 64'(bus.done_v_o), 64'd0);
    pulse(4'b1000);
    @(negedge clk);
    check("t3_dv_l3", 64'(bus.done_v_o), 64'd1);
    tick();

    // asynchronous reset during WAIT drops the in-flight instruction
    send(3'd5, 5'd3, 5'd6, 5'd8, 32'hCAFE, 1'b0);
    tick();
    pulse(4'b0011);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("arst");
    resp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    send(3'd6, 5'd11, 5'd12, 5'd13, 32'h0BAD_F00D, 1'b0);
    tick();
    pulse(4'b1111);
    @(negedge clk);
    check("t4_dv_after_rst", 64'(bus.done_v_o), 64'd1);
    tick();

    // only lanes 0-2 respond
`ifdef VEC_ISSUE_TIMEOUT_EN
    send(3'd7, 5'd13, 5'd14, 5'd15, 32'h55, 1'b1);
`else
    send(3'd7, 5'd13, 5'd14, 5'd15, 32'h55, 1'b0);
`endif
    tick();
    pulse(4'b0111);
    early = 1'b0;
    for (int i = 2; i <= 64; i++) begin
      @(negedge clk);
      if (bus.done_v_o) early = 1'b1;
      tick();
    end
    check("t5_no_early_resp", 64'(early), 64'd0);
    @(negedge clk);
`ifdef VEC_ISSUE_TIMEOUT_EN
    check("t5_timeout_dv",  64'(bus.done_v_o), 64'd1);
    check("t5_timeout_err", 64'(bus.done_err_o), 64'd1);
    tick();
    @(negedge clk);
    check("t5_err_cleared", 64'(bus.done_err_o), 64'd0);
`else
    check("t5_still_waiting", 64'(bus.done_v_o), 64'd0);
    check("t5_busy",          64'(bus.busy_o), 64'd1);
    tick();
    pulse(4'b1000);
    @(negedge clk);
    check("t5_late_dv", 64'(bus.done_v_o), 64'd1);
    tick();
`endif
    tick();

    check("issue_q_empty", 64'(issue_q.size()), 64'd0);
    check("resp_q_empty",  64'(resp_q.size()),  64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
